// File: rtl/i2c_sensor_scheduler.sv
// Init + periodic six-axis poll sequencer in front of the shared I2C transaction engine.
// Optional feature macro: SCHED_RETRY_EN (reissue a NACKed transaction up to MAX_RETRY times).
module i2c_sensor_scheduler #(
   parameter int POLL_DIV    = 100000,
   parameter int STARTUP_CYC = 5000,
   parameter int MAX_RETRY   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic        txn_valid,
   input  logic        txn_ready,
   output logic        txn_rw,
   output logic [7:0]  txn_slave,
   output logic [7:0]  txn_reg,
   output logic [7:0]  txn_wdata,
   input  logic        txn_done,
   input  logic        txn_nack,
   input  logic [15:0] txn_rdata,
   output logic [31:0] PC_acl_x,
   output logic [31:0] PC_acl_y,
   output logic [31:0] PC_acl_z,
   output logic [31:0] PC_mag_x,
   output logic [31:0] PC_mag_y,
   output logic [31:0] PC_mag_z,
   output logic        sample_valid,
   output logic        init_done,
   output logic        overrun,
   output logic [7:0]  err_cnt
);

   localparam int PW  = $clog2(POLL_DIV);
   localparam int SW  = $clog2(STARTUP_CYC + 1);
   localparam int RTW = $clog2(MAX_RETRY + 2);
`ifdef SCHED_RETRY_EN
   localparam int RETRY_LIMIT = MAX_RETRY;
`else
   localparam int RETRY_LIMIT = MAX_RETRY * 0;
`endif

   localparam logic [2:0] SLOT_MZ     = 3'd5;
   localparam logic [2:0] SLOT_INIT_A = 3'd6;
   localparam logic [2:0] SLOT_INIT_M = 3'd7;

   typedef enum logic [2:0] {
      S_WAIT_START, S_INIT_A, S_INIT_M, S_IDLE, S_ISSUE, S_WAIT_DONE, S_PUBLISH
   } state_t;

   state_t           r_state;
   logic [PW-1:0]    r_poll_cnt;
   logic [SW-1:0]    r_start_cnt;
   logic [RTW-1:0]   r_retry;
   logic [2:0]       r_slot;
   logic [15:0]      r_shadow [0:4];
   logic             r_txn_valid;
   logic             r_txn_rw;
   logic [7:0]       r_txn_slave;
   logic [7:0]       r_txn_reg;
   logic [7:0]       r_txn_wdata;
   logic [31:0]      r_acl_x, r_acl_y, r_acl_z, r_mag_x, r_mag_y, r_mag_z;
   logic             r_sample_valid;
   logic             r_init_done;
   logic             r_overrun;
   logic [7:0]       r_err_cnt;

   logic             w_tick;
   logic [15:0]      w_value;

   // Slots 0..5 are the axis reads, 6/7 the two init writes: {rw, slave, reg, wdata}.
   function automatic logic [24:0] txn_fields(input logic [2:0] idx);
      case (idx)
         3'd0:    return {1'b1, 8'h32, 8'hA8, 8'h00};
         3'd1:    return {1'b1, 8'h32, 8'hAA, 8'h00};
         3'd2:    return {1'b1, 8'h32, 8'hAC, 8'h00};
         3'd3:    return {1'b1, 8'h3C, 8'h03, 8'h00};
         3'd4:    return {1'b1, 8'h3C, 8'h07, 8'h00};
         3'd5:    return {1'b1, 8'h3C, 8'h05, 8'h00};
         3'd6:    return {1'b0, 8'h32, 8'h20, 8'h37};
         default: return {1'b0, 8'h3C, 8'h02, 8'h00};
      endcase
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   assign w_tick  = (r_poll_cnt == '0);
   // Accel returns low byte first, magnetometer high byte first.
   assign w_value = (r_slot >= 3'd3) ? {txn_rdata[7:0], txn_rdata[15:8]} : txn_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_poll_cnt <= '0;
      end else if (w_tick) begin
         r_poll_cnt <= PW'(POLL_DIV - 1);
      end else begin
         r_poll_cnt <= r_poll_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      if (!rst_n) begin
         r_state     <= S_WAIT_START;
         r_start_cnt <= '0;
         r_retry     <= '0;
         r_slot      <= '0;
         r_txn_valid <= 1'b0;
         r_txn_rw    <= 1'b0;
         r_txn_slave <= '0;
         r_txn_reg   <= '0;
         r_txn_wdata <= '0;
         r_acl_x     <= '0;
         r_acl_y     <= '0;
         r_acl_z     <= '0;
         r_mag_x     <= '0;
         r_mag_y     <= '0;
         r_mag_z     <= '0;
         r_init_done <= 1'b0;
         r_err_cnt   <= '0;
         for (int i = 0; i < 5; i++) r_shadow[i] <= '0;
      end else begin
         if (w_tick && r_state != S_IDLE && r_state != S_WAIT_START) r_overrun <= 1'b1;
         case (r_state)
            S_WAIT_START: begin
               if (r_start_cnt == SW'(STARTUP_CYC - 1)) begin
                  r_state     <= S_INIT_A;
                  r_slot      <= SLOT_INIT_A;
                  r_txn_valid <= 1'b1;
                  {r_txn_rw, r_txn_slave, r_txn_reg, r_txn_wdata} <= txn_fields(SLOT_INIT_A);
               end else begin
                  r_start_cnt <= r_start_cnt + 1'b1;
               end
            end
            S_INIT_A, S_INIT_M, S_ISSUE: begin
               if (txn_ready) begin
                  r_txn_valid <= 1'b0;
                  r_state     <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (txn_done && txn_nack) begin
                  r_err_cnt <= (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;
                  if (r_retry < RTW'(RETRY_LIMIT)) begin
                     r_retry     <= r_retry + 1'b1;
                     r_txn_valid <= 1'b1;
                     r_state     <= (r_slot == SLOT_INIT_A) ? S_INIT_A :
                                    (r_slot == SLOT_INIT_M) ? S_INIT_M : S_ISSUE;
                  end else begin
                     r_retry <= '0;
                     r_state <= S_IDLE;
                  end
               end else if (txn_done) begin
                  r_retry <= '0;
                  if (r_slot == SLOT_INIT_A) begin
                     r_state     <= S_INIT_M;
                     r_slot      <= SLOT_INIT_M;
                     r_txn_valid <= 1'b1;
                     {r_txn_rw, r_txn_slave, r_txn_reg, r_txn_wdata} <= txn_fields(SLOT_INIT_M);
                  end else if (r_slot == SLOT_INIT_M) begin
                     r_init_done <= 1'b1;
                     r_state     <= S_IDLE;
                  end else if (r_slot == SLOT_MZ) begin
                     // Last axis bypasses its shadow so the frame publishes one cycle after done.
                     r_acl_x        <= sext16(r_shadow[0]);
                     r_acl_y        <= sext16(r_shadow[1]);
                     r_acl_z        <= sext16(r_shadow[2]);
                     r_mag_x        <= sext16(r_shadow[3]);
                     r_mag_y        <= sext16(r_shadow[4]);
                     r_mag_z        <= sext16(w_value);
                     r_sample_valid <= 1'b1;
                     r_state        <= S_PUBLISH;
                  end else begin
                     r_shadow[r_slot] <= w_value;
                     r_slot           <= r_slot + 3'd1;
                     r_txn_valid      <= 1'b1;
                     {r_txn_rw, r_txn_slave, r_txn_reg, r_txn_wdata} <= txn_fields(r_slot + 3'd1);
                     r_state          <= S_ISSUE;
                  end
               end
            end
            S_IDLE: begin
               if (w_tick && !r_init_done) begin
                  r_state     <= S_INIT_A;
                  r_slot      <= SLOT_INIT_A;
                  r_txn_valid <= 1'b1;
                  {r_txn_rw, r_txn_slave, r_txn_reg, r_txn_wdata} <= txn_fields(SLOT_INIT_A);
               end else if (w_tick && enable) begin
                  r_state     <= S_ISSUE;
                  r_slot      <= 3'd0;
                  r_txn_valid <= 1'b1;
                  {r_txn_rw, r_txn_slave, r_txn_reg, r_txn_wdata} <= txn_fields(3'd0);
               end
            end
            S_PUBLISH: r_state <= S_IDLE;
            default:   r_state <= S_WAIT_START;
         endcase
      end
   end

   assign txn_valid    = r_txn_valid;
   assign txn_rw       = r_txn_rw;
   assign txn_slave    = r_txn_slave;
   assign txn_reg      = r_txn_reg;
   assign txn_wdata    = r_txn_wdata;
   assign PC_acl_x     = r_acl_x;
   assign PC_acl_y     = r_acl_y;
   assign PC_acl_z     = r_acl_z;
   assign PC_mag_x     = r_mag_x;
   assign PC_mag_y     = r_mag_y;
   assign PC_mag_z     = r_mag_z;
   assign sample_valid = r_sample_valid;
   assign init_done    = r_init_done;
   assign overrun      = r_overrun;
   assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_i2c_sensor_scheduler.sv
// Directed bench for i2c_sensor_scheduler with a behavioural I2C engine responder.
module tb_i2c_sensor_scheduler;
   localparam int POLL_DIV    = 40;
   localparam int STARTUP_CYC = 4;
   localparam int MAX_RETRY   = 3;
`ifdef SCHED_RETRY_EN
   localparam int NACK_ABORT = MAX_RETRY + 1;
`else
   localparam int NACK_ABORT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        txn_valid, txn_rw;
   logic        txn_ready = 1'b0;
   logic [7:0]  txn_slave, txn_reg, txn_wdata;
   logic        txn_done = 1'b0;
   logic        txn_nack = 1'b0;
   logic [15:0] txn_rdata = '0;
   logic [31:0] PC_acl_x, PC_acl_y, PC_acl_z, PC_mag_x, PC_mag_y, PC_mag_z;
   logic        sample_valid, init_done, overrun;
   logic [7:0]  err_cnt;

   always #5 clk = ~clk;

   i2c_sensor_scheduler #(.POLL_DIV(POLL_DIV), .STARTUP_CYC(STARTUP_CYC), .MAX_RETRY(MAX_RETRY)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_rw(txn_rw),
      .txn_slave(txn_slave), .txn_reg(txn_reg), .txn_wdata(txn_wdata),
      .txn_done(txn_done), .txn_nack(txn_nack), .txn_rdata(txn_rdata),
      .PC_acl_x(PC_acl_x), .PC_acl_y(PC_acl_y), .PC_acl_z(PC_acl_z),
      .PC_mag_x(PC_mag_x), .PC_mag_y(PC_mag_y), .PC_mag_z(PC_mag_z),
      .sample_valid(sample_valid), .init_done(init_done), .overrun(overrun), .err_cnt(err_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Responder controls and logs
   int          stall_req = 0;
   int          lat = 1;
   logic [7:0]  nack_reg = 8'hFF;
   int          nack_left = 0;
   logic [15:0] rd_tab [6];
   logic [7:0]  log_reg[$];
   logic [7:0]  log_slave[$];
   logic [7:0]  log_wdata[$];
   logic        log_rw[$];
   int          cyc = 0;
   int          done_cyc = 0;
   int          sv_cnt = 0;
   int          sv_cyc = 0;
   int          ovr_cnt = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (sample_valid) begin
         sv_cnt++;
         sv_cyc = cyc;
      end
      if (overrun) ovr_cnt++;
   end

   function automatic logic [15:0] rd_lookup(input logic [7:0] r);
      case (r)
         8'hA8:   return rd_tab[0];
         8'hAA:   return rd_tab[1];
         8'hAC:   return rd_tab[2];
         8'h03:   return rd_tab[3];
         8'h07:   return rd_tab[4];
         8'h05:   return rd_tab[5];
         default: return 16'h0000;
      endcase
   endfunction

   // Engine model: accept after optional stall, done after lat negedges.
   initial begin
      int          tmr;
      int          stall;
      logic        busy;
      logic        in_txn;
      logic        stalled;
      logic        pnack;
      logic [15:0] prd;
      logic [24:0] snap;
      tmr = 0; stall = 0; busy = 0; in_txn = 0; stalled = 0; pnack = 0; prd = '0; snap = '0;
      forever begin
         @(negedge clk);
         txn_done = 1'b0;
         txn_nack = 1'b0;
         if (busy) begin
            if (tmr == 0) begin
               txn_done  = 1'b1;
               txn_nack  = pnack;
               txn_rdata = prd;
               busy      = 1'b0;
               done_cyc  = cyc;
               $display("txn rw=%0b slave=%h reg=%h wdata=%h rdata=%h nack=%0b",
                        snap[24], snap[23:16], snap[15:8], snap[7:0], prd, pnack);
            end else begin
               tmr--;
            end
         end
         if (txn_ready) begin
            txn_ready = 1'b0;
            in_txn    = 1'b0;
            busy      = 1'b1;
            tmr       = lat;
            if (stalled) chk("valid_drop", {31'd0, txn_valid}, 32'd0);
            log_rw.push_back(snap[24]);
            log_slave.push_back(snap[23:16]);
            log_reg.push_back(snap[15:8]);
            log_wdata.push_back(snap[7:0]);
            pnack = (snap[15:8] == nack_reg) && (nack_left > 0);
            if (pnack) nack_left--;
            prd = rd_lookup(snap[15:8]);
         end else if (txn_valid && !busy) begin
            if (!in_txn) begin
               in_txn    = 1'b1;
               snap      = {txn_rw, txn_slave, txn_reg, txn_wdata};
               stall     = stall_req;
               stall_req = 0;
               stalled   = (stall > 0);
            end
            if (stall > 0) begin
               chk("stall_fields", {7'd0, txn_rw, txn_slave, txn_reg, txn_wdata}, {7'd0, snap});
               stall--;
            end else begin
               txn_ready = 1'b1;
            end
         end
      end
   end

   task automatic wait_sample(input int budget, output logic ok);
      int s0;
      s0 = sv_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sv_cnt != s0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic set_rd(input logic [15:0] a0, a1, a2, a3, a4, a5);
      rd_tab[0] = a0; rd_tab[1] = a1; rd_tab[2] = a2;
      rd_tab[3] = a3; rd_tab[4] = a4; rd_tab[5] = a5;
   endtask

   task automatic clear_log();
      log_reg.delete(); log_slave.delete(); log_wdata.delete(); log_rw.delete();
   endtask

   logic [7:0] exp_regs [6] = '{8'hA8, 8'hAA, 8'hAC, 8'h03, 8'h07, 8'h05};

   initial begin
      int   first;
      int   s0;
      int   e0;
      int   o0;
      int   last7;
      logic ok;

      set_rd(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, txn_valid}, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_acl_x", PC_acl_x, 32'd0);
      chk("rst_mag_z", PC_mag_z, 32'd0);

      // Startup delay and init writes
      rst_n  = 1'b1;
      enable = 1'b1;
      first  = 0;
      for (int k = 1; k <= 10 && first == 0; k++) begin
         @(negedge clk);
         if (txn_valid) first = k;
      end
      chk("startup_cycle", first, 4);
      for (int i = 0; i < 50 && !init_done; i++) @(negedge clk);
      chk("init_done", {31'd0, init_done}, 32'd1);
      chk("init_a_slave", {24'd0, log_slave[0]}, 32'h32);
      chk("init_a_reg", {24'd0, log_reg[0]}, 32'h20);
      chk("init_a_wdata", {24'd0, log_wdata[0]}, 32'h37);
      chk("init_a_rw", {31'd0, log_rw[0]}, 32'd0);
      chk("init_m_slave", {24'd0, log_slave[1]}, 32'h3C);
      chk("init_m_reg", {24'd0, log_reg[1]}, 32'h02);
      chk("init_m_wdata", {24'd0, log_wdata[1]}, 32'h00);
      chk("init_m_rw", {31'd0, log_rw[1]}, 32'd0);

      // Frame 1: all slots return 80FF
      clear_log();
      set_rd(16'h80FF, 16'h80FF, 16'h80FF, 16'h80FF, 16'h80FF, 16'h80FF);
      s0 = sv_cnt;
      wait_sample(200, ok);
      chk("f1_sample", {31'd0, ok}, 32'd1);
      repeat (2) @(negedge clk);
      chk("f1_one_pulse", sv_cnt - s0, 1);
      chk("f1_latency", sv_cyc - done_cyc, 1);
      chk("f1_acl_x", PC_acl_x, 32'hFFFF80FF);
      chk("f1_mag_x", PC_mag_x, 32'hFFFFFF80);
      for (int i = 0; i < 6; i++) chk($sformatf("f1_order%0d", i), {24'd0, log_reg[i]}, {24'd0, exp_regs[i]});
      chk("f1_slave_mz", {24'd0, log_slave[5]}, 32'h3C);
      chk("f1_rw_ax", {31'd0, log_rw[0]}, 32'd1);

      // Frame 2: distinct values, both byte orders and signs
      set_rd(16'h1234, 16'h7FFF, 16'h8000, 16'h3412, 16'h0180, 16'hFF7F);
      wait_sample(200, ok);
      chk("f2_sample", {31'd0, ok}, 32'd1);
      chk("f2_acl_x", PC_acl_x, 32'h00001234);
      chk("f2_acl_y", PC_acl_y, 32'h00007FFF);
      chk("f2_acl_z", PC_acl_z, 32'hFFFF8000);
      chk("f2_mag_x", PC_mag_x, 32'h00001234);
      chk("f2_mag_y", PC_mag_y, 32'hFFFF8001);
      chk("f2_mag_z", PC_mag_z, 32'h00007FFF);

      // NACK on MY aborts the frame
      clear_log();
      set_rd(16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
      e0 = int'(err_cnt);
      s0 = sv_cnt;
      nack_reg  = 8'h07;
      nack_left = NACK_ABORT;
      for (int i = 0; i < 600 && int'(err_cnt) != e0 + NACK_ABORT; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("nack_err_cnt", {24'd0, err_cnt}, e0 + NACK_ABORT);
      chk("nack_no_sample", sv_cnt - s0, 0);
      chk("nack_keep_acl_x", PC_acl_x, 32'h00001234);
      chk("nack_keep_mag_y", PC_mag_y, 32'hFFFF8001);
      nack_reg = 8'hFF;
      wait_sample(200, ok);
      chk("nack_next_sample", {31'd0, ok}, 32'd1);
      last7 = -1;
      for (int i = 0; i < log_reg.size(); i++) if (log_reg[i] == 8'h07 && i < log_reg.size() - 6) last7 = i;
      chk("nack_restart_ax", {24'd0, log_reg[last7 + 1]}, 32'hA8);
      chk("nack_new_acl_x", PC_acl_x, 32'h00005555);
      chk("nack_new_mag_z", PC_mag_z, 32'h00005555);

      // Ready withheld for 10 cycles on the first read
      clear_log();
      set_rd(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
      stall_req = 10;
      wait_sample(300, ok);
      chk("stall_sample", {31'd0, ok}, 32'd1);
      chk("stall_first_reg", {24'd0, log_reg[0]}, 32'hA8);
      chk("stall_acl_z", PC_acl_z, 32'h00000001);
      chk("stall_mag_x", PC_mag_x, 32'h00000100);

      // Slow engine: ticks land mid-frame
      clear_log();
      set_rd(16'hFEDC, 16'hFEDC, 16'hFEDC, 16'hFEDC, 16'hFEDC, 16'hFEDC);
      lat = 20;
      o0  = ovr_cnt;
      wait_sample(800, ok);
      lat = 1;
      chk("slow_sample", {31'd0, ok}, 32'd1);
      chk("slow_overrun_seen", {31'd0, ovr_cnt > o0}, 32'd1);
      for (int i = 0; i < 6; i++) chk($sformatf("slow_order%0d", i), {24'd0, log_reg[i]}, {24'd0, exp_regs[i]});
      chk("slow_acl_y", PC_acl_y, 32'hFFFFFEDC);
      chk("slow_mag_y", PC_mag_y, 32'hFFFFDCFE);

      // Polling held off while disabled
      repeat (2) @(negedge clk);
      enable = 1'b0;
      clear_log();
      s0 = sv_cnt;
      repeat (130) @(negedge clk);
      chk("dis_no_txn", log_reg.size(), 0);
      chk("dis_no_sample", sv_cnt - s0, 0);
      enable = 1'b1;
      wait_sample(200, ok);
      chk("reen_sample", {31'd0, ok}, 32'd1);

`ifdef SCHED_RETRY_EN
      // Two NACKs then ACK on AZ are absorbed by retries
      clear_log();
      e0 = int'(err_cnt);
      nack_reg  = 8'hAC;
      nack_left = 2;
      wait_sample(300, ok);
      nack_reg = 8'hFF;
      chk("retry_sample", {31'd0, ok}, 32'd1);
      chk("retry_err_cnt", {24'd0, err_cnt}, e0 + 2);
      chk("retry_txn_count", log_reg.size(), 8);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
